aska_dig_fpga_top: RTL and testbench
====================================

// Module: aska_dig_fpga_top
// PURPOSE
//  FPGA board top for the ASKA digital stimulator. Receives four 32-bit config registers
//  over a 4-wire SPI slave and divides clk_25mhz to a 20 kHz tick.
//  Drives biphasic ramped current pulses: 6-bit DAC code plus up/down electrode
//  switches, all on the gn header. The board/ASIC front end consumes the outputs.
// PARAMETERS
//  CLK_DIV    1250  clk_25mhz cycles per 20 kHz tick (toggle gn[0] every CLK_DIV/2)
//  ELEC_NUM   31    electrode mask MSB index (mask width ELEC_NUM+1 = 32)
// PORTS
//  clk_25mhz  in   1   system clock, 25 MHz
//  gp[0]      in   1   resetn: asynchronous, active-low, full reset
//  gp[1]      in   1   porborn: async active-low brown-out; clears engine and outputs, keeps config
//  gp[2]      in   1   SPI_Clk; gp[3] SPI_MOSI; gp[4] SPI_CS (active-low); gp[5] unused
//  btn        in   7   unused
//  gn[0]      out  1   clk_20khz, 50% duty
//  gn[3:1]    out  3   up_switches; gn[6:4] down_switches
//  gn[12:7]   out  6   DAC code; gn[13] pulse_active
//  led        out  8   {DAC[5:0], pulse_active, enable}
// BEHAVIOUR
//  Reset: all outputs 0, all registers 0, divider and SPI counters cleared.
//  SPI (mode 0, MSB first): MOSI sampled on SCK rising edge in the SCK domain.
//   - CS high asynchronously clears the bit counter.
//   - Frame = addr byte, then data[31:24], [23:16], [15:8], [7:0].
//   - SCK may be faster than clk_25mhz, so shift and count in the SCK domain.
//   - CS passes a 2-FF synchronizer into clk_25mhz. On the sync'd CS rising edge,
//     commit the 40-bit frame only if exactly 40 bits were clocked; otherwise discard.
//   - Addr 0 = conf0, 1 = conf1, 2 = ele1, 3 = ele2; other addresses ignored.
//  conf0: [11:0] freq (period in ticks), [17:12] amplitude, [23:18] ramp, [31:24] ON_time (pulses).
//  conf1: [9:0] ramp_factor (4 fractional bits), [19:10] OFF_time (periods),
//   [20] enable, [23:21] phase (ticks per phase), [31:24] reserved (read as written, ignored).
//  Tick: one-cycle strobe coincident with gn[0] rising edge; all engine timing in ticks.
//  FSM, advanced on ticks:
//   - IDLE: entered while enable=0. On enable=1: clear acc; pulse counter = 0; enter ON.
//   - ON: period counter runs 0..freq-1.
//     At count 0: acc = min(acc+ramp_factor, amplitude<<4).
//     Forced to amplitude<<4 if ramp==0 or ramp_factor==0.
//   - PHASE_A (phase ticks): DAC=acc[9:4]; up=ele1[15:13]; down=ele2[15:13].
//   - GAP (1 tick): DAC=0, switches 0.
//   - PHASE_B (phase ticks): DAC=acc[9:4]; up=ele2[15:13]; down=ele1[15:13].
//   - pulse_active=1 throughout PHASE_A, GAP, PHASE_B; DAC/switches 0 elsewhere.
//   - After ON_time pulses: OFF for OFF_time full periods (outputs 0), then clear acc, back to ON.
//   - ON_time=0: stay in OFF. OFF_time=0: return to ON immediately.
//  Boundaries:
//   - phase=0 is treated as 1.
//   - freq < 2*phase+1 is clamped to 2*phase+1.
//   - acc is 10 bits and saturates, never wraps.
//  Timing of config changes:
//   - Writes while running take effect at the next period start.
//   - enable=0 (on commit) forces IDLE at the next tick, aborting any pulse.
//  porborn low: FSM to IDLE, acc 0, outputs 0; registers and divider keep running.
//   On porborn release: resume from IDLE; restart the ramp if enable=1.
// TESTING
//  1. Reset: resetn low -> gn=0, led=0. Release -> gn[0] toggles every 625 clk (20 kHz).
//  2. SPI write addr 2 data 0x00008000 then addr 3 data 0x00004000 -> ele1/ele2 hold
//     those values; 32-bit (truncated) frame to addr 0 -> conf0 unchanged.
//  3. conf0 amp=50 freq=400 ramp=25 ON=25, conf1 rf=32 OFF=25 en=1 phase=4:
//     pulses every 400 ticks (50 Hz); each shows PHASE_A 4 ticks up=100 down=010,
//     GAP 1 tick, PHASE_B 4 ticks up=010 down=100.
//  4. Ramp: DAC 2,4,...,50 on pulses 1..25. Then 25 silent periods (0.5 s).
//     Next ON restarts at DAC=2.
//  5. Write conf1 with en=0 mid-pulse -> outputs 0 within 1 tick; re-enable -> ramp restarts at 2.
//  6. porborn low 1 ms mid-ON -> outputs 0. Release -> ramp restarts without SPI rewrite.

Source files
------------

// File: rtl/aska_dig_fpga_top.sv
// ASKA digital stimulator FPGA top: SPI-loaded configuration, 20 kHz tick divider and a
// biphasic ramped pulse engine driving the DAC code and electrode switches on the gn header.
module aska_dig_fpga_top #(
  parameter int unsigned CLK_DIV  = 1250,
  parameter int unsigned ELEC_NUM = 31
) (
  input  logic        clk_25mhz,
  input  logic [5:0]  gp,
  input  logic [6:0]  btn,
  output logic [13:0] gn,
  output logic [7:0]  led
);

  localparam int unsigned HalfDiv = CLK_DIV / 2;
  localparam int unsigned DivW    = (HalfDiv > 1) ? $clog2(HalfDiv) : 1;

  typedef enum logic [1:0] {StIdle, StOn, StOff} state_e;

  logic rst_n, porb_n, eng_rst_n;
  logic spi_sck, spi_mosi, spi_cs_n, spi_rst_n;

  assign rst_n     = gp[0];
  assign porb_n    = gp[1];
  assign eng_rst_n = rst_n & porb_n;
  assign spi_sck   = gp[2];
  assign spi_mosi  = gp[3];
  assign spi_cs_n  = gp[4];
  assign spi_rst_n = rst_n & ~spi_cs_n;

  // ---------------- tick divider ----------------
  logic [DivW-1:0] div_cnt_q, div_cnt_d;
  logic            clk20_q, clk20_d, tick_q, tick_d, div_end;

  assign div_end = (div_cnt_q == DivW'(HalfDiv - 1));

  always_comb begin
    div_cnt_d = div_end ? '0 : div_cnt_q + DivW'(1);
    clk20_d   = div_end ? ~clk20_q : clk20_q;
    tick_d    = div_end & ~clk20_q;
  end

  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      clk20_q   <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      clk20_q   <= clk20_d;
      tick_q    <= tick_d;
    end
  end

  // ---------------- SPI slave (SCK domain) ----------------
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [39:0] shift_q, shift_d;
  logic        frame_ok_q, frame_ok_d;

  always_comb begin
    bit_cnt_d  = (bit_cnt_q == 6'd63) ? bit_cnt_q : bit_cnt_q + 6'd1;
    shift_d    = {shift_q[38:0], spi_mosi};
    frame_ok_d = (bit_cnt_q == 6'd39);
  end

  always_ff @(posedge spi_sck or negedge spi_rst_n) begin
    if (!spi_rst_n) bit_cnt_q <= '0;
    else            bit_cnt_q <= bit_cnt_d;
  end

  // Frame data and length flag survive CS high so the clk domain can read them after sync.
  always_ff @(posedge spi_sck or negedge rst_n) begin
    if (!rst_n) begin
      shift_q    <= '0;
      frame_ok_q <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      frame_ok_q <= frame_ok_d;
    end
  end

  // ---------------- CS sync and config registers ----------------
  logic [2:0]        cs_sync_q;
  logic              cs_rise;
  logic [31:0]       conf0_q, conf0_d, conf1_q, conf1_d;
  logic [ELEC_NUM:0] ele1_q, ele1_d, ele2_q, ele2_d;

  assign cs_rise = cs_sync_q[1] & ~cs_sync_q[2];

  always_comb begin
    conf0_d = conf0_q;
    conf1_d = conf1_q;
    ele1_d  = ele1_q;
    ele2_d  = ele2_q;
    if (cs_rise && frame_ok_q) begin
      case (shift_q[39:32])
        8'd0:    conf0_d = shift_q[31:0];
        8'd1:    conf1_d = shift_q[31:0];
        8'd2:    ele1_d  = (ELEC_NUM + 1)'(shift_q[31:0]);
        8'd3:    ele2_d  = (ELEC_NUM + 1)'(shift_q[31:0]);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync_q <= '0;
      conf0_q   <= '0;
      conf1_q   <= '0;
      ele1_q    <= '0;
      ele2_q    <= '0;
    end else begin
      cs_sync_q <= {cs_sync_q[1:0], spi_cs_n};
      conf0_q   <= conf0_d;
      conf1_q   <= conf1_d;
      ele1_q    <= ele1_d;
      ele2_q    <= ele2_d;
    end
  end

  // ---------------- live configuration fields ----------------
  logic [11:0] freq_l, min_freq_l, freq_eff_l;
  logic [5:0]  amp_l, ramp_l;
  logic [7:0]  on_l;
  logic [9:0]  rf_l, off_l, amp_top_l, acc_cont, acc_fresh;
  logic [2:0]  phase_l, ph_l;
  logic        en_l;

  assign freq_l     = conf0_q[11:0];
  assign amp_l      = conf0_q[17:12];
  assign ramp_l     = conf0_q[23:18];
  assign on_l       = conf0_q[31:24];
  assign rf_l       = conf1_q[9:0];
  assign off_l      = conf1_q[19:10];
  assign en_l       = conf1_q[20];
  assign phase_l    = conf1_q[23:21];
  assign ph_l       = (phase_l == 3'd0) ? 3'd1 : phase_l;
  assign min_freq_l = {8'd0, ph_l, 1'b1};
  assign freq_eff_l = (freq_l < min_freq_l) ? min_freq_l : freq_l;
  assign amp_top_l  = {amp_l, 4'd0};

  function automatic logic [9:0] ramp_step(input logic [9:0] base, input logic [9:0] rf,
                                           input logic [9:0] top, input logic forced);
    logic [10:0] sum;
    sum = {1'b0, base} + {1'b0, rf};
    if (forced || (sum > {1'b0, top})) return top;
    return sum[9:0];
  endfunction

  assign acc_cont  = ramp_step(acc_q, rf_l, amp_top_l, (ramp_l == 6'd0) || (rf_l == 10'd0));
  assign acc_fresh = ramp_step(10'd0, rf_l, amp_top_l, (ramp_l == 6'd0) || (rf_l == 10'd0));

  // ---------------- pulse engine ----------------
  state_e      state_q, state_d;
  logic [11:0] per_cnt_q, per_cnt_d, sh_freq_q, sh_freq_d;
  logic [7:0]  pulse_cnt_q, pulse_cnt_d, sh_on_q, sh_on_d;
  logic [9:0]  off_cnt_q, off_cnt_d, acc_q, acc_d, sh_off_q, sh_off_d;
  logic [2:0]  sh_ph_q, sh_ph_d, sh_ea_q, sh_ea_d, sh_eb_q, sh_eb_d;
  logic        per_end, pulses_done, offs_done, go_on, go_off, latch;

  assign per_end     = (per_cnt_q == sh_freq_q - 12'd1);
  assign pulses_done = ({1'b0, pulse_cnt_q} + 9'd1) >= {1'b0, sh_on_q};
  assign offs_done   = ({1'b0, off_cnt_q} + 11'd1) >= {1'b0, sh_off_q};

  always_ff @(posedge clk_25mhz or negedge eng_rst_n) begin
    if (!eng_rst_n) begin
      state_q     <= StIdle;
      per_cnt_q   <= '0;
      pulse_cnt_q <= '0;
      off_cnt_q   <= '0;
      acc_q       <= '0;
      sh_freq_q   <= '0;
      sh_on_q     <= '0;
      sh_off_q    <= '0;
      sh_ph_q     <= '0;
      sh_ea_q     <= '0;
      sh_eb_q     <= '0;
    end else begin
      state_q     <= state_d;
      per_cnt_q   <= per_cnt_d;
      pulse_cnt_q <= pulse_cnt_d;
      off_cnt_q   <= off_cnt_d;
      acc_q       <= acc_d;
      sh_freq_q   <= sh_freq_d;
      sh_on_q     <= sh_on_d;
      sh_off_q    <= sh_off_d;
      sh_ph_q     <= sh_ph_d;
      sh_ea_q     <= sh_ea_d;
      sh_eb_q     <= sh_eb_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    per_cnt_d   = per_cnt_q;
    pulse_cnt_d = pulse_cnt_q;
    off_cnt_d   = off_cnt_q;
    acc_d       = acc_q;
    sh_freq_d   = sh_freq_q;
    sh_on_d     = sh_on_q;
    sh_off_d    = sh_off_q;
    sh_ph_d     = sh_ph_q;
    sh_ea_d     = sh_ea_q;
    sh_eb_d     = sh_eb_q;
    go_on       = 1'b0;
    go_off      = 1'b0;
    latch       = 1'b0;
    if (tick_q) begin
      if (!en_l) begin
        state_d = StIdle;
        acc_d   = '0;
      end else begin
        case (state_q)
          StIdle: go_on = 1'b1;
          StOn: begin
            if (!per_end) begin
              per_cnt_d = per_cnt_q + 12'd1;
            end else if (!pulses_done) begin
              per_cnt_d   = '0;
              pulse_cnt_d = pulse_cnt_q + 8'd1;
              acc_d       = acc_cont;
              latch       = 1'b1;
            end else if (off_l == 10'd0) begin
              go_on = 1'b1;
            end else begin
              go_off = 1'b1;
            end
          end
          StOff: begin
            if (!per_end) begin
              per_cnt_d = per_cnt_q + 12'd1;
            end else if (offs_done) begin
              go_on = 1'b1;
            end else begin
              per_cnt_d = '0;
              off_cnt_d = off_cnt_q + 10'd1;
              latch     = 1'b1;
            end
          end
          default: state_d = StIdle;
        endcase
        // A zero ON_time parks the engine in OFF, re-checked every period.
        if (go_on && (on_l == 8'd0)) go_off = 1'b1;
        if (go_off) begin
          state_d   = StOff;
          per_cnt_d = '0;
          off_cnt_d = '0;
          acc_d     = '0;
          latch     = 1'b1;
        end else if (go_on) begin
          state_d     = StOn;
          per_cnt_d   = '0;
          pulse_cnt_d = '0;
          acc_d       = acc_fresh;
          latch       = 1'b1;
        end
        if (latch) begin
          sh_freq_d = freq_eff_l;
          sh_on_d   = on_l;
          sh_off_d  = off_l;
          sh_ph_d   = ph_l;
          sh_ea_d   = ele1_q[15:13];
          sh_eb_d   = ele2_q[15:13];
        end
      end
    end
  end

  // ---------------- outputs ----------------
  logic [11:0] ph12, ph2;
  logic [5:0]  dac;
  logic [2:0]  up_sw, down_sw;
  logic        active;

  assign ph12 = {9'd0, sh_ph_q};
  assign ph2  = {8'd0, sh_ph_q, 1'b0};

  always_comb begin
    dac     = '0;
    up_sw   = '0;
    down_sw = '0;
    active  = 1'b0;
    if (state_q == StOn) begin
      if (per_cnt_q < ph12) begin
        active  = 1'b1;
        dac     = acc_q[9:4];
        up_sw   = sh_ea_q;
        down_sw = sh_eb_q;
      end else if (per_cnt_q == ph12) begin
        active = 1'b1;
      end else if (per_cnt_q <= ph2) begin
        active  = 1'b1;
        dac     = acc_q[9:4];
        up_sw   = sh_eb_q;
        down_sw = sh_ea_q;
      end
    end
  end

  assign gn  = {active, dac, down_sw, up_sw, clk20_q};
  assign led = {dac, active, en_l & porb_n};

  logic unused_bits;
  assign unused_bits = ^{btn, gp[5], conf1_q[31:24], ele1_q[ELEC_NUM:16], ele1_q[12:0],
                         ele2_q[ELEC_NUM:16], ele2_q[12:0]};

endmodule

// File: tb/tb_aska_dig_fpga_top.sv
// Directed self-checking bench for aska_dig_fpga_top using a shortened tick divider.
`timescale 1ns / 1ps
module tb_aska_dig_fpga_top;

  localparam int unsigned ClkDiv = 8;
  localparam logic [2:0]  Ea     = 3'b100;
  localparam logic [2:0]  Eb     = 3'b010;

  logic        clk = 1'b0;
  logic [5:0]  gp;
  logic [6:0]  btn;
  logic [13:0] gn;
  logic [7:0]  led;

  int n_asserts = 0;
  int n_fail    = 0;

  aska_dig_fpga_top #(.CLK_DIV(ClkDiv), .ELEC_NUM(31)) dut (
    .clk_25mhz(clk),
    .gp       (gp),
    .btn      (btn),
    .gn       (gn),
    .led      (led)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the middle of the next tick (sampled just after gn[0] falls).
  task automatic step_tick();
    int n = 0;
    do begin @(posedge clk); #1; n++; end while (gn[0] !== 1'b1 && n < 4 * ClkDiv);
    do begin @(posedge clk); #1; n++; end while (gn[0] !== 1'b0 && n < 4 * ClkDiv);
    check("tick_wait", (n < 4 * ClkDiv) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic find_pulse(input string tag, input int maxn, output int n);
    n = 0;
    do begin step_tick(); n++; end while (gn[13] !== 1'b1 && n < maxn);
    check({tag, "_found"}, {31'd0, gn[13]}, 32'd1);
  endtask

  task automatic check_pulse(input string tag, input logic [5:0] dac, input int ph);
    logic [12:0] exp;
    for (int i = 0; i <= 2 * ph; i++) begin
      if (i > 0) step_tick();
      if (i < ph)       exp = {1'b1, dac, Eb, Ea};
      else if (i == ph) exp = 13'h1000;
      else              exp = {1'b1, dac, Ea, Eb};
      check(tag, {19'd0, gn[13:1]}, {19'd0, exp});
      if (i == 0) check({tag, "_led"}, {24'd0, led}, {24'd0, dac, 2'b11});
    end
  endtask

  task automatic spi_write(input logic [7:0] addr, input logic [31:0] data, input int nbits);
    logic [39:0] frame;
    frame = {addr, data};
    gp[4] = 1'b0;
    #7;
    for (int i = 0; i < nbits; i++) begin
      if (i < 40) gp[3] = frame[39 - i];
      else        gp[3] = 1'b0;
      #3 gp[2] = 1'b1;
      #3 gp[2] = 1'b0;
    end
    #3 gp[4] = 1'b1;
    #40;
  endtask

  initial begin
    int n;
    gp  = 6'b01_0010;
    btn = '0;

    // Reset state and divider
    repeat (3) @(posedge clk);
    #1;
    check("reset_gn", {18'd0, gn}, 32'd0);
    check("reset_led", {24'd0, led}, 32'd0);
    @(negedge clk);
    gp[0] = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (gn[0] !== 1'b1 && n < 100);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (gn[0] !== 1'b0 && n < 100);
    check("div_high", n, ClkDiv / 2);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (gn[0] !== 1'b1 && n < 100);
    check("div_low", n, ClkDiv / 2);

    // SPI framing
    spi_write(8'd2, 32'h0000_8000, 40);
    spi_write(8'd3, 32'h0000_4000, 40);
    check("ele1", dut.ele1_q, 32'h0000_8000);
    check("ele2", dut.ele2_q, 32'h0000_4000);
    spi_write(8'd0, 32'h1234_5678, 32);
    check("short_frame", dut.conf0_q, 32'd0);
    spi_write(8'd0, 32'h1234_5678, 41);
    check("long_frame", dut.conf0_q, 32'd0);
    spi_write(8'd4, 32'h1234_5678, 40);
    check("bad_addr_c0", dut.conf0_q, 32'd0);
    check("bad_addr_c1", dut.conf1_q, 32'd0);
    check("idle_out", {19'd0, gn[13:1]}, 32'd0);

    // freq 20, amp 7, ramp 5, ON 4 / rf 48, OFF 2, en, phase 2
    spi_write(8'd0, 32'h0414_7014, 40);
    check("conf0", dut.conf0_q, 32'h0414_7014);
    spi_write(8'd1, 32'h0050_0830, 40);
    check("conf1", dut.conf1_q, 32'h0050_0830);
    check("led_en", {31'd0, led[0]}, 32'd1);

    find_pulse("p1", 50, n);
    check_pulse("p1", 6'd3, 2);
    find_pulse("p2", 50, n);
    check("period_p2", 4 + n, 20);
    check_pulse("p2", 6'd6, 2);
    find_pulse("p3", 50, n);
    check_pulse("p3", 6'd7, 2);
    find_pulse("p4", 50, n);
    check_pulse("p4", 6'd7, 2);
    find_pulse("p5", 100, n);
    check("period_off", 4 + n, 60);
    check_pulse("p5", 6'd3, 2);

    // Disable mid-pulse
    find_pulse("p6", 50, n);
    spi_write(8'd1, 32'h0040_0830, 40);
    step_tick();
    step_tick();
    check("dis_gn", {19'd0, gn[13:1]}, 32'd0);
    check("dis_led", {24'd0, led}, 32'd0);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      step_tick();
      if (gn[13]) n++;
    end
    check("dis_quiet", n, 0);

    // Re-enable restarts the ramp
    spi_write(8'd1, 32'h0050_0830, 40);
    find_pulse("re1", 50, n);
    check_pulse("re1", 6'd3, 2);
    find_pulse("re2", 50, n);
    check("re2_dac", {26'd0, gn[12:7]}, 32'd6);

    // Brown-out during a pulse
    gp[1] = 1'b0;
    #1;
    check("porb_gn", {19'd0, gn[13:1]}, 32'd0);
    check("porb_led", {24'd0, led}, 32'd0);
    check("porb_acc", {22'd0, dut.acc_q}, 32'd0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      step_tick();
      if (gn[13:1] != 13'd0) n++;
    end
    check("porb_quiet", n, 0);
    gp[1] = 1'b1;
    find_pulse("rel1", 50, n);
    check_pulse("rel1", 6'd3, 2);
    check("porb_conf0", dut.conf0_q, 32'h0414_7014);

    // phase 0 -> 1, freq 1 -> 3, ramp 0 forces full amplitude 9
    spi_write(8'd1, 32'h0040_0830, 40);
    step_tick();
    step_tick();
    spi_write(8'd0, 32'h0400_9001, 40);
    spi_write(8'd1, 32'h0010_0830, 40);
    find_pulse("c1", 50, n);
    check_pulse("c1", 6'd9, 1);
    find_pulse("c2", 50, n);
    check("period_clamp", 2 + n, 3);
    check_pulse("c2", 6'd9, 1);
    find_pulse("c3", 50, n);
    check_pulse("c3", 6'd9, 1);
    find_pulse("c4", 50, n);
    check_pulse("c4", 6'd9, 1);
    find_pulse("c5", 50, n);
    check("period_clamp_off", 2 + n, 9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
